// File: rtl/r8_booth_seq_ctrl.sv
// Radix-8 Booth multiply sequencer: one digit of B per cycle through
// an external partial-product selector, accumulating a 32-bit product.
module r8_booth_seq_ctrl #(
  parameter bit APPROX = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a_in,
  input  logic [15:0] b_in,
  output logic [15:0] pp_a,
  output logic        pp_neg,
  output logic        pp_f0,
  output logic        pp_f1,
  output logic        pp_f2,
  output logic        pp_f3,
  output logic        pp_f4,
  input  logic [31:0] pp_prod,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] product,
  output logic        busy
);

  localparam int NDIG = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  cnt;
  logic [31:0] acc;
  logic [31:0] acc_nxt;
  logic [31:0] prod_q;
  logic [15:0] a_q;
  logic [18:0] b_ext;
  logic [4:0]  shamt;
  logic [3:0]  g;
  logic [2:0]  mag;
  logic        neg;
  logic        accept;
  logic        last;

  assign accept  = (state == IDLE) && in_valid;
  assign last    = (cnt == 3'(NDIG - 1));
  assign shamt   = 5'(cnt) * 5'd3;
  assign acc_nxt = acc + (pp_prod << shamt);
  assign g       = 4'(b_ext >> shamt);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (in_valid) state_nxt = RUN;
      RUN:  if (last) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      acc    <= '0;
      prod_q <= '0;
      a_q    <= '0;
      b_ext  <= '0;
    end else if (accept) begin
      cnt    <= '0;
      acc    <= '0;
      prod_q <= '0;
      a_q    <= a_in;
      b_ext  <= {b_in[15], b_in[15], b_in, 1'b0};
    end else if (state == RUN) begin
      acc <= acc_nxt;
      if (last) begin
        prod_q <= acc_nxt;
      end else begin
        cnt <= cnt + 3'd1;
      end
    end
  end

  // Booth window to sign/magnitude; both zero codes map to +0.
  always_comb begin
    mag = 3'd0;
    neg = 1'b0;
    unique case (g)
      4'b0001, 4'b0010: mag = 3'd1;
      4'b0011, 4'b0100: mag = 3'd2;
      4'b0101, 4'b0110: mag = 3'd3;
      4'b0111:          mag = 3'd4;
      4'b1000: begin
        mag = 3'd4;
        neg = 1'b1;
      end
      4'b1001, 4'b1010: begin
        mag = 3'd3;
        neg = 1'b1;
      end
      4'b1011, 4'b1100: begin
        mag = 3'd2;
        neg = 1'b1;
      end
      4'b1101, 4'b1110: begin
        mag = 3'd1;
        neg = 1'b1;
      end
      default: begin
        mag = 3'd0;
        neg = 1'b0;
      end
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
    product   = prod_q;
    pp_a      = a_q;
    pp_neg    = 1'b0;
    pp_f0     = 1'b0;
    pp_f1     = 1'b0;
    pp_f2     = 1'b0;
    pp_f3     = 1'b0;
    pp_f4     = 1'b0;
    if (state == RUN) begin
      pp_neg = neg;
      unique case (1'b1)
        (mag == 3'd1): pp_f0 = 1'b1;
        (mag == 3'd2): pp_f1 = 1'b1;
        (mag == 3'd3): begin
          pp_f2 = !APPROX;
          pp_f4 = APPROX;
        end
        (mag == 3'd4): pp_f3 = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_r8_booth_seq_ctrl.sv
// Bench for r8_booth_seq_ctrl: exact and approximate instances run in
// lockstep against a behavioural selector and a*b reference.
module tb_r8_booth_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] a_in = '0;
  logic [15:0] b_in = '0;

  logic        in_ready0, in_ready1;
  logic [15:0] pp_a0, pp_a1;
  logic        neg0, neg1;
  logic [4:0]  fv0, fv1;
  logic [31:0] pp_prod0, pp_prod1;
  logic        out_valid0, out_valid1;
  logic [31:0] product0, product1;
  logic        busy0, busy1;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] sel_model(
    input logic [15:0] a, input logic neg, input logic [4:0] f
  );
    int m;
    int v;
    m = 0;
    if (f[0]) m = 1;
    if (f[1]) m = 2;
    if (f[2]) m = 3;
    if (f[3]) m = 4;
    if (f[4]) m = 4;
    v = int'($signed(a)) * m;
    if (neg) v = -v;
    return 32'(v);
  endfunction

  assign pp_prod0 = sel_model(pp_a0, neg0, fv0);
  assign pp_prod1 = sel_model(pp_a1, neg1, fv1);

  r8_booth_seq_ctrl #(.APPROX(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready0),
    .a_in(a_in), .b_in(b_in),
    .pp_a(pp_a0), .pp_neg(neg0),
    .pp_f0(fv0[0]), .pp_f1(fv0[1]), .pp_f2(fv0[2]),
    .pp_f3(fv0[3]), .pp_f4(fv0[4]),
    .pp_prod(pp_prod0),
    .out_valid(out_valid0), .out_ready(out_ready),
    .product(product0), .busy(busy0)
  );

  r8_booth_seq_ctrl #(.APPROX(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready1),
    .a_in(a_in), .b_in(b_in),
    .pp_a(pp_a1), .pp_neg(neg1),
    .pp_f0(fv1[0]), .pp_f1(fv1[1]), .pp_f2(fv1[2]),
    .pp_f3(fv1[3]), .pp_f4(fv1[4]),
    .pp_prod(pp_prod1),
    .out_valid(out_valid1), .out_ready(out_ready),
    .product(product1), .busy(busy1)
  );

  // Starts and ends at a negedge with both instances idle.
  task automatic run_op(
    input logic [15:0] a, input logic [15:0] b, input int hold
  );
    logic [31:0] exp;
    logic [18:0] bext;
    logic [3:0]  g;
    logic [4:0]  ef0, ef1;
    logic        en;
    int d, mag;
    exp = 32'(int'($signed(a)) * int'($signed(b)));
    bext = {b[15], b[15], b, 1'b0};
    total++;
    if (in_ready0 !== 1'b1 || in_ready1 !== 1'b1) begin
      bad++;
      $display("FAIL idle_ready got=%b/%b want=1", in_ready0, in_ready1);
    end
    a_in = a;
    b_in = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      g = bext[3*i +: 4];
      d = -4 * int'(g[3]) + 2 * int'(g[2]) + int'(g[1]) + int'(g[0]);
      mag = (d < 0) ? -d : d;
      en = (d < 0);
      ef0 = (mag == 0) ? 5'd0 : 5'(1 << (mag - 1));
      ef1 = (mag == 3) ? 5'b10000 : ef0;
      total++;
      if (fv0 !== ef0 || neg0 !== en) begin
        bad++;
        $display("FAIL sel_exact dig=%0d got f=%b n=%b want f=%b n=%b",
                 i, fv0, neg0, ef0, en);
      end
      total++;
      if (fv1 !== ef1 || neg1 !== en) begin
        bad++;
        $display("FAIL sel_approx dig=%0d got f=%b n=%b want f=%b n=%b",
                 i, fv1, neg1, ef1, en);
      end
      total++;
      if ($countones(fv0) > 1 || $countones(fv1) > 1 ||
          out_valid0 !== 1'b0 || busy0 !== 1'b1 ||
          in_ready0 !== 1'b0 || pp_a0 !== a) begin
        bad++;
        $display("FAIL run_flags dig=%0d got f=%b/%b ov=%b bz=%b ir=%b a=%h",
                 i, fv0, fv1, out_valid0, busy0, in_ready0, pp_a0);
      end
      @(negedge clk);
    end
    total++;
    if (out_valid0 !== 1'b1 || product0 !== exp ||
        out_valid1 !== 1'b1 || fv0 !== 5'd0 || neg0 !== 1'b0) begin
      bad++;
      $display("FAIL done a=%h b=%h got ov=%b p=%h f=%b want ov=1 p=%h",
               a, b, out_valid0, product0, fv0, exp);
    end
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      a_in = 16'($urandom);
      b_in = 16'($urandom);
      @(negedge clk);
      total++;
      if (out_valid0 !== 1'b1 || product0 !== exp ||
          in_ready0 !== 1'b0 || busy0 !== 1'b1) begin
        bad++;
        $display("FAIL hold cyc=%0d got ov=%b p=%h ir=%b want ov=1 p=%h ir=0",
                 h, out_valid0, product0, in_ready0, exp);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1 ||
        busy0 !== 1'b0 || product0 !== exp || out_valid1 !== 1'b0) begin
      bad++;
      $display("FAIL handoff got ov=%b ir=%b bz=%b p=%h want 0/1/0 p=%h",
               out_valid0, in_ready0, busy0, product0, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (in_ready0 !== 1'b1 || out_valid0 !== 1'b0 || busy0 !== 1'b0 ||
        product0 !== 32'd0 || pp_a0 !== 16'd0 || fv0 !== 5'd0 ||
        neg0 !== 1'b0 || in_ready1 !== 1'b1 || product1 !== 32'd0) begin
      bad++;
      $display("FAIL reset got ir=%b ov=%b bz=%b p=%h a=%h f=%b n=%b",
               in_ready0, out_valid0, busy0, product0, pp_a0, fv0, neg0);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    run_op(16'd3, 16'd5, 0);
    run_op(16'd7, 16'd3, 0);
    run_op(16'hFFFB, 16'd100, 0);
  endtask

  task automatic test_corners();
    run_op(16'h8000, 16'h8000, 0);
    run_op(16'h7FFF, 16'h7FFF, 0);
    run_op(16'hFFFF, 16'h0001, 0);
    run_op(16'h0000, 16'h8000, 0);
    run_op(16'h8000, 16'h7FFF, 0);
  endtask

  task automatic test_backpressure();
    run_op(16'h1234, 16'hFEDC, 10);
  endtask

  task automatic test_reset_mid_run();
    in_valid = 1'b1;
    a_in = 16'h4321;
    b_in = 16'h5A5A;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    total++;
    if (in_ready0 !== 1'b1 || out_valid0 !== 1'b0 || busy0 !== 1'b0 ||
        product0 !== 32'd0 || pp_a0 !== 16'd0 || fv0 !== 5'd0) begin
      bad++;
      $display("FAIL mid_reset got ir=%b ov=%b bz=%b p=%h want 1/0/0 p=0",
               in_ready0, out_valid0, busy0, product0);
    end
    repeat (8) begin
      @(negedge clk);
      total++;
      if (out_valid0 !== 1'b0 || busy0 !== 1'b0) begin
        bad++;
        $display("FAIL mid_reset_quiet got ov=%b bz=%b want 0/0",
                 out_valid0, busy0);
      end
    end
    run_op(16'hABCD, 16'h0FED, 0);
  endtask

  task automatic test_approx();
    run_op(16'd9, 16'd3, 0);
    run_op(16'hFF00, 16'hFFFD, 0);
  endtask

  task automatic test_back_to_back();
    logic [15:0] a, b;
    for (int n = 0; n < 2000; n++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      if (n % 7 == 0) b = 16'h8000 | 16'($urandom_range(0, 7));
      if (n % 11 == 0) a = 16'h7FFF;
      run_op(a, b, 0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_backpressure();
    test_reset_mid_run();
    test_approx();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
